// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for mem_access_unit
`include "defines.sv"

package mem_access_pkg;

   localparam int WORD_LEN = `WORD_LEN;

   // Default number of BUSY cycles tolerated before a bus access is aborted
   localparam int TIMEOUT_CYCLES_DEFAULT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/ack memory bus between the MEM stage and memory
interface mem_access_unit_if;
   import mem_access_pkg::*;

   logic                mem_req;
   logic                mem_we;
   logic [WORD_LEN-1:0] mem_addr;
   logic [WORD_LEN-1:0] mem_wdata;
   logic                mem_ack;
   logic [WORD_LEN-1:0] mem_rdata;

   // The MEM stage issues requests; the memory answers with ack/rdata
   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/defines.sv
// rtl/defines.sv - global word width for the memory stage
`ifndef MEM_ACCESS_DEFINES_SV
`define MEM_ACCESS_DEFINES_SV
`define WORD_LEN 16
`endif

// File: rtl/mem_access_unit_watchdog.sv
// rtl/mem_access_unit_watchdog.sv - BUSY cycle counter that flags a stuck bus access
module mem_watchdog
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Count consecutive BUSY cycles; any non-BUSY cycle restarts the count
   always_comb begin
      count_d = count_q;
      if (busy) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds the number of BUSY cycles already completed, so this fires
   // during the TIMEOUT_CYCLES-th BUSY cycle
   assign expired = busy && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage bus access FSM (optional timeout: MEM_TIMEOUT_EN)
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WORD_LEN-1:0] PR3_alu_out,
   input  logic [WORD_LEN-1:0] PR3_RF_out2,
   input  logic                PR3_MEM_read_en,
   input  logic                PR3_MEM_write_en,
   mem_access_unit_if.master   bus,
   output logic [WORD_LEN-1:0] MEM_out,
   output logic                MEM_stall,
   output logic                MEM_error
);

   mem_state_e          state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
   logic [WORD_LEN-1:0] mem_out_q, mem_out_d;
   logic                access;
   logic                timeout_hit;

   assign access = PR3_MEM_read_en | PR3_MEM_write_en;

`ifdef MEM_TIMEOUT_EN
   logic mem_error_q, mem_error_d;

   mem_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst),
      .busy    (state_q == ST_BUSY),
      .expired (timeout_hit)
   );

   assign MEM_error = mem_error_q;
`else
   // The parameter has no effect when the access may wait forever
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
   assign MEM_error   = 1'b0;
`endif

   // Next-state and next-output logic for the IDLE -> BUSY -> DONE sequence
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_out_d   = mem_out_q;
`ifdef MEM_TIMEOUT_EN
      mem_error_d = mem_error_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               // a simultaneous read and write request is treated as a store
               mem_req_d   = 1'b1;
               mem_we_d    = PR3_MEM_write_en;
               mem_addr_d  = PR3_alu_out;
               mem_wdata_d = PR3_RF_out2;
               state_d     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // ack wins over a timeout landing in the same cycle
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  mem_out_d = bus.mem_rdata;
               end
               state_d = ST_DONE;
            end else if (timeout_hit) begin
               mem_req_d = 1'b0;
               mem_out_d = '1;
`ifdef MEM_TIMEOUT_EN
               mem_error_d = 1'b1;
`endif
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // one free cycle so the stalled pipeline advances past this access
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered bus/result outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_out_q   <= '0;
`ifdef MEM_TIMEOUT_EN
         mem_error_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_out_q   <= mem_out_d;
`ifdef MEM_TIMEOUT_EN
         mem_error_q <= mem_error_d;
`endif
      end
   end

   // Stall is combinational so the pipeline freezes in the detect cycle itself
   assign MEM_stall = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && access);

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign MEM_out       = mem_out_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit (MEM_TIMEOUT_EN optional)
module tb_mem_access_unit;
   import mem_access_pkg::*;

   localparam int W  = WORD_LEN;
   localparam int TO = TIMEOUT_CYCLES_DEFAULT;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] alu;
   logic [W-1:0] rf2;
   logic         rd_en;
   logic         wr_en;
   logic [W-1:0] mem_out;
   logic         mem_stall;
   logic         mem_error;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rises  = 0;
   bit cmp_en = 0;
   logic req_prev = 0;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk              (clk),
      .rst              (rst),
      .PR3_alu_out      (alu),
      .PR3_RF_out2      (rf2),
      .PR3_MEM_read_en  (rd_en),
      .PR3_MEM_write_en (wr_en),
      .bus              (bus),
      .MEM_out          (mem_out),
      .MEM_stall        (mem_stall),
      .MEM_error        (mem_error)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: an access is either outstanding, just finished, or absent
   bit           m_busy, m_done, m_req, m_we, m_err;
   logic [W-1:0] m_addr, m_wdata, m_out;
   int           m_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 0; m_done = 0; m_req = 0; m_we = 0; m_err = 0;
         m_addr = '0; m_wdata = '0; m_out = '0; m_cnt = 0;
      end else if (m_busy) begin
         m_cnt = m_cnt + 1;
         if (bus.mem_ack) begin
            m_busy = 0; m_done = 1; m_req = 0;
            if (!m_we) m_out = bus.mem_rdata;
         end else if (TO_EN && m_cnt == TO) begin
            m_busy = 0; m_done = 1; m_req = 0; m_out = '1; m_err = 1;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (rd_en || wr_en) begin
         m_busy = 1; m_req = 1; m_we = wr_en;
         m_addr = alu; m_wdata = rf2; m_cnt = 0;
      end
   end

   // Single compare process against the model, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_stall", mem_stall, m_busy || (!m_done && (rd_en || wr_en)));
         check("model_req",   bus.mem_req, m_req);
         check("model_we",    bus.mem_we, m_we);
         check("model_addr",  bus.mem_addr, m_addr);
         check("model_wdata", bus.mem_wdata, m_wdata);
         check("model_out",   mem_out, m_out);
         check("model_err",   mem_error, m_err);
      end
      if (bus.mem_req && !req_prev) rises++;
      req_prev = bus.mem_req;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Called at posedge+2 of the cycle in which the request is presented
   task automatic run_access(input logic rd, input logic wr,
                             input logic [W-1:0] addr, input logic [W-1:0] wdata,
                             input logic [W-1:0] rdata, input int ack_after,
                             output int stalls, output logic [W-1:0] out_done,
                             output logic we_b1, output logic [W-1:0] addr_b1,
                             output logic req_det, output int done_c, output int req_c);
      bit hit;
      hit = 0; stalls = 0; out_done = 'x; we_b1 = 'x; addr_b1 = 'x;
      req_det = 'x; done_c = -1; req_c = -1;
      rd_en = rd; wr_en = wr; alu = addr; rf2 = wdata; bus.mem_ack = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!mem_stall) begin
            out_done = mem_out; done_c = cyc; hit = 1;
            break;
         end
         if (stalls == 0) req_det = bus.mem_req;
         if (stalls == 1) begin
            we_b1 = bus.mem_we; addr_b1 = bus.mem_addr; req_c = cyc;
         end
         stalls++;
         @(posedge clk);
         #2;
         if (ack_after > 0 && stalls >= ack_after) begin
            bus.mem_ack = 1; bus.mem_rdata = rdata;
         end
      end
      if (!hit) check("access_bound", 32'd0, 32'd1);
      @(posedge clk);
      #2;
      rd_en = 0; wr_en = 0; bus.mem_ack = 0;
   endtask

   int           st, dc1, dc2, rc2;
   logic [W-1:0] out_v, addr_v;
   logic         we_v, rdet;

   initial begin
      rst = 0; rd_en = 0; wr_en = 0; alu = '0; rf2 = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_req",   bus.mem_req, 1'b0);
      check("rst_we",    bus.mem_we, 1'b0);
      check("rst_addr",  bus.mem_addr, 16'h0000);
      check("rst_out",   mem_out, 16'h0000);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_err",   mem_error, 1'b0);
      rst = 1; cmp_en = 1;
      idle(1);

      // read at 0x0010, ack in the first BUSY cycle
      run_access(1, 0, 16'h0010, 16'h0000, 16'h1234, 1, st, out_v, we_v, addr_v, rdet, dc1, rc2);
      check("rd_stalls", st, 2);
      check("rd_out", out_v, 16'h1234);
      check("rd_addr", addr_v, 16'h0010);
      check("rd_we", we_v, 1'b0);

      // write 0xBEEF at 0x0020, ack in the fourth BUSY cycle
      idle(2);
      run_access(0, 1, 16'h0020, 16'hBEEF, 16'h5555, 4, st, out_v, we_v, addr_v, rdet, dc1, rc2);
      check("wr_stalls", st, 5);
      check("wr_out_kept", out_v, 16'h1234);
      check("wr_we", we_v, 1'b1);
      check("wr_addr", addr_v, 16'h0020);

      // both enables: store wins
      idle(1);
      run_access(1, 1, 16'h0030, 16'h0A0A, 16'h7777, 2, st, out_v, we_v, addr_v, rdet, dc1, rc2);
      check("both_we", we_v, 1'b1);
      check("both_out", out_v, 16'h1234);
      check("both_stalls", st, 3);

      // two loads back to back
      idle(1);
      rises = 0;
      run_access(1, 0, 16'h0040, 16'h0000, 16'hA5A5, 1, st, out_v, we_v, addr_v, rdet, dc1, rc2);
      check("b2b_out1", out_v, 16'hA5A5);
      run_access(1, 0, 16'h0042, 16'h0000, 16'h5A5A, 1, st, out_v, we_v, addr_v, rdet, dc2, rc2);
      check("b2b_req_low_idle", rdet, 1'b0);
      check("b2b_req_gap", rc2 - dc1, 2);
      check("b2b_out2", out_v, 16'h5A5A);
      check("b2b_rises", rises, 2);

      // reset in the middle of BUSY, then stray acks
      rd_en = 1; alu = 16'h0050;
      idle(2);
      rst = 0; rd_en = 0;
      #1;
      check("mid_rst_req", bus.mem_req, 1'b0);
      check("mid_rst_out", mem_out, 16'h0000);
      check("mid_rst_stall", mem_stall, 1'b0);
      idle(1);
      rst = 1; bus.mem_ack = 1; bus.mem_rdata = 16'h9999;
      idle(3);
      bus.mem_ack = 0;
      @(negedge clk);
      check("late_ack_req", bus.mem_req, 1'b0);
      check("late_ack_out", mem_out, 16'h0000);
      check("late_ack_stall", mem_stall, 1'b0);
      @(posedge clk);
      #2;

`ifdef MEM_TIMEOUT_EN
      // ack in the last allowed cycle beats the timeout
      run_access(1, 0, 16'h0060, 16'h0000, 16'h1111, 15, st, out_v, we_v, addr_v, rdet, dc1, rc2);
      check("to_ack15_stalls", st, 16);
      check("to_ack15_out", out_v, 16'h1111);
      check("to_ack15_err", mem_error, 1'b0);
      // no ack at all
      run_access(1, 0, 16'h0062, 16'h0000, 16'h0000, 0, st, out_v, we_v, addr_v, rdet, dc1, rc2);
      check("to_stalls", st, 16);
      check("to_out", out_v, 16'hFFFF);
      check("to_err", mem_error, 1'b1);
      idle(3);
      check("to_err_sticky", mem_error, 1'b1);
`else
      // without the watchdog a slow memory is simply waited for
      run_access(1, 0, 16'h0060, 16'h0000, 16'h2222, 40, st, out_v, we_v, addr_v, rdet, dc1, rc2);
      check("long_stalls", st, 41);
      check("long_out", out_v, 16'h2222);
      check("long_err", mem_error, 1'b0);
`endif

      idle(2);
      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL sim_time_limit actual=expired required=finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 15: BUSY cycles without ack before abort; used only with MEM_TIMEOUT_EN.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 PR3_alu_out  in  WORD_LEN  access address from the EX/MEM register.
REQ-006 PR3_RF_out2  in  WORD_LEN  store data from the EX/MEM register.
REQ-007 PR3_MEM_read_en  in  1  load request.
REQ-008 PR3_MEM_write_en  in  1  store request.
REQ-009 mem_req  out  1  bus request, registered.
REQ-010 mem_we  out  1  bus write strobe, registered.
REQ-011 mem_addr  out  WORD_LEN  bus address, registered.
REQ-012 mem_wdata  out  WORD_LEN  bus write data, registered.
REQ-013 mem_ack  in  1  bus completion; valid only while mem_req=1.
REQ-014 mem_rdata  in  WORD_LEN  bus read data, valid with mem_ack.
REQ-015 MEM_out  out  WORD_LEN  load result, registered; drives PR3_MEM_out into the MEM/WB register.
REQ-016 MEM_stall  out  1  combinational hold for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-017 MEM_error  out  1  sticky bus-timeout flag.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-019 IDLE with read_en or write_en SHALL assert MEM_stall combinationally and, at the next edge:
- latch address, data and direction into mem_addr, mem_wdata and mem_we;
- set mem_req=1;
- enter BUSY.
REQ-020 If read_en and write_en are both 1, the access SHALL be a write.
REQ-021 IDLE with neither enable SHALL keep MEM_stall=0 and mem_req=0.
REQ-022 BUSY SHALL keep MEM_stall=1 and hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack.
REQ-023 BUSY with mem_ack SHALL, at that edge:
- clear mem_req;
- load mem_rdata into MEM_out if the access is a read;
- enter DONE.
REQ-024 DONE SHALL hold MEM_stall=0 for exactly one cycle, ignore the PR3 enables and return to IDLE.
REQ-025 Minimum access latency SHALL be 3 cycles: detect, one BUSY cycle, DONE.
REQ-026 Back-to-back accesses SHALL be accepted in the IDLE cycle that follows DONE.
REQ-027 Writes SHALL leave MEM_out unchanged.
REQ-028 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-029 Reset asserted (rst=0) SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MEM_out=0 and MEM_error=0; MEM_stall=0 follows from IDLE.
REQ-030 Reset mid-BUSY SHALL abandon the access; a late mem_ack SHALL be ignored.

Configuration
REQ-031 With MEM_TIMEOUT_EN defined, a BUSY cycle counter SHALL run. After TIMEOUT_CYCLES BUSY cycles without ack, the block SHALL:
- clear mem_req;
- set MEM_out to all ones;
- set MEM_error=1 (sticky until reset);
- enter DONE.
REQ-032 With MEM_TIMEOUT_EN defined, mem_ack in the same cycle as the timeout SHALL take priority; MEM_error stays unchanged.
REQ-033 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely, no counter SHALL be built, and MEM_error SHALL be tied to 0.

Structure
REQ-034 Package mem_access_pkg SHALL hold the state enum typedef and the default TIMEOUT_CYCLES constant.
REQ-035 WORD_LEN SHALL come from defines.sv.
REQ-036 Sub-module mem_watchdog (counter plus expiry compare) SHALL be instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-037 Read, addr 0x0010, ack on the first BUSY cycle with rdata 0x1234 -> MEM_stall high for 2 cycles; MEM_out=0x1234 in DONE; total 3 cycles.
REQ-038 Write, addr 0x0020, data 0xBEEF, ack after 4 BUSY cycles -> mem_we=1, addr and data stable throughout; MEM_out unchanged; stall 5 cycles.
REQ-039 read_en=1 and write_en=1 together -> mem_we=1.
REQ-040 Two consecutive loads -> second mem_req rises exactly one cycle after the DONE cycle; no duplicate request for the first.
REQ-041 rst=0 during BUSY, then ack pulses after release -> mem_req=0 immediately, state IDLE, MEM_out=0, ack ignored.
REQ-042 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> after 15 BUSY cycles MEM_error=1 and MEM_out=0xFFFF (16-bit word); ack on the 15th cycle -> MEM_error stays 0.
